// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, derived totals, default sync
// polarity and the coordinate width shared by vga_timing and its counters.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 2**COORD_W;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam logic SYNC_ACTIVE_DEF = 1'b0;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF =
    axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping 0..TOTAL-1 counter for one raster axis.
//   i_clk, i_reset_n : clock, async active-low reset (count -> 0)
//   i_en             : advance one step (wraps from TOTAL-1 to 0)
//   o_count          : current position
//   o_tc             : count == TOTAL-1
//   o_in_range       : RANGE_LO <= count <= RANGE_HI (inclusive)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL    = 800,
  parameter int unsigned RANGE_LO = 656,
  parameter int unsigned RANGE_HI = 751
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_count,
  output logic               o_tc,
  output logic               o_in_range
);

  logic [COORD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_en) begin
      count_d = o_tc ? '0 : count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count    = count_q;
  assign o_tc       = (count_q == COORD_W'(TOTAL - 1));
  assign o_in_range = (count_q >= COORD_W'(RANGE_LO)) && (count_q <= COORD_W'(RANGE_HI));

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator. Pixel strobe divider, X/Y counters,
// visible/line/frame decodes, and a pin-aligned output register for sync
// and renderer colour.
//   i_clk, i_reset_n     : clock, async active-low reset
//   i_r, i_g, i_b        : renderer colour for the current pixel
//   o_pix_en             : pixel strobe, one i_clk wide
//   o_pixel_x/o_pixel_y  : current pixel coordinates
//   o_visible            : current pixel is in the active area
//   o_line_tick          : last pixel of a line is being consumed
//   o_frame_tick         : pixel (0, TICK_LINE) is being consumed
//   o_hsync/o_vsync      : registered sync, aligned with o_r/o_g/o_b
//   o_r, o_g, o_b        : registered colour, blanked outside the active area
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_DEF,
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned TICK_LINE   = 481
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_r,
  input  logic               i_g,
  input  logic               i_b,
  output logic               o_pix_en,
  output logic [COORD_W-1:0] o_pixel_x,
  output logic [COORD_W-1:0] o_pixel_y,
  output logic               o_visible,
  output logic               o_line_tick,
  output logic               o_frame_tick,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_r,
  output logic               o_g,
  output logic               o_b
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > COORD_MAX) begin : g_h_total_err
    $error("vga_timing: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_err
    $error("vga_timing: V_TOTAL exceeds coordinate range");
  end
  if (CLK_DIV < 1) begin : g_clk_div_err
    $error("vga_timing: CLK_DIV must be at least 1");
  end

  // The strobe is registered so it is 0 during reset; div_q therefore runs one
  // cycle ahead of pix_en_q, and the first strobe lands CLK_DIV edges after release.
  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  logic [COORD_W-1:0] x, y;
  logic               h_tc, h_sync_rng, v_sync_rng, h_wrap;
  logic               v_tc_unused;  // frame tick decodes TICK_LINE, not the V wrap

  assign h_wrap = pix_en_q & h_tc;

  vga_axis_counter #(
    .TOTAL   (H_TOTAL),
    .RANGE_LO(H_VISIBLE + H_FRONT),
    .RANGE_HI(H_VISIBLE + H_FRONT + H_SYNC - 1)
  ) u_h_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (pix_en_q),
    .o_count   (x),
    .o_tc      (h_tc),
    .o_in_range(h_sync_rng)
  );

  vga_axis_counter #(
    .TOTAL   (V_TOTAL),
    .RANGE_LO(V_VISIBLE + V_FRONT),
    .RANGE_HI(V_VISIBLE + V_FRONT + V_SYNC - 1)
  ) u_v_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (h_wrap),
    .o_count   (y),
    .o_tc      (v_tc_unused),
    .o_in_range(v_sync_rng)
  );

  assign o_pix_en     = pix_en_q;
  assign o_pixel_x    = x;
  assign o_pixel_y    = y;
  assign o_visible    = (x < COORD_W'(H_VISIBLE)) && (y < COORD_W'(V_VISIBLE));
  assign o_line_tick  = h_wrap;
  assign o_frame_tick = pix_en_q && (x == '0) && (y == COORD_W'(TICK_LINE));

  // Sync and colour for pixel N are captured on the same strobe so the pins
  // carry them with identical one-pixel latency.
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en_q) begin
      hsync_d = h_sync_rng ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = v_sync_rng ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_d   = {i_r, i_g, i_b} & {3{o_visible}};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_r     = rgb_q[2];
  assign o_g     = rgb_q[1];
  assign o_b     = rgb_q[0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing. One full-size instance covers
// reset values and the 640-wide line; three reduced-geometry instances
// (23x12 raster) cover whole frames, CLK_DIV=2 and inverted sync polarity.
module tb_vga_timing;

  localparam int HT = 23, VT = 12, HV = 16, VV = 6, TL = 7, FRAME = HT * VT;
  localparam int HS_LO = 18, HS_HI = 20, VS_LO = 8, VS_HI = 9;
  localparam logic [28:0] RST_OBS = {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_r = 1'b1, in_g = 1'b1, in_b = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic       d0_pe, d0_vis, d0_lt, d0_ft, d0_hs, d0_vs, d0_r, d0_g, d0_b;
  logic [9:0] d0_x, d0_y;
  logic       s_pe, s_vis, s_lt, s_ft, s_hs, s_vs, s_r, s_g, s_b;
  logic [9:0] s_x, s_y;
  logic       p_pe, p_vis, p_lt, p_ft, p_hs, p_vs, p_r, p_g, p_b;
  logic [9:0] p_x, p_y;
  logic       c_pe, c_vis, c_lt, c_ft, c_hs, c_vs, c_r, c_g, c_b;
  logic [9:0] c_x, c_y;

  wire logic [28:0] d0_obs = {d0_pe, d0_x, d0_y, d0_vis, d0_lt, d0_ft, d0_hs, d0_vs, d0_r, d0_g, d0_b};
  wire logic [28:0] s_obs  = {s_pe, s_x, s_y, s_vis, s_lt, s_ft, s_hs, s_vs, s_r, s_g, s_b};
  wire logic [28:0] p_obs  = {p_pe, p_x, p_y, p_vis, p_lt, p_ft, p_hs, p_vs, p_r, p_g, p_b};
  wire logic [28:0] c_obs  = {c_pe, c_x, c_y, c_vis, c_lt, c_ft, c_hs, c_vs, c_r, c_g, c_b};

  vga_timing u_d0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_pix_en(d0_pe), .o_pixel_x(d0_x), .o_pixel_y(d0_y), .o_visible(d0_vis),
    .o_line_tick(d0_lt), .o_frame_tick(d0_ft), .o_hsync(d0_hs), .o_vsync(d0_vs),
    .o_r(d0_r), .o_g(d0_g), .o_b(d0_b)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0), .CLK_DIV(1), .TICK_LINE(7)
  ) u_s (
    .i_clk(clk), .i_reset_n(rst_n), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_pix_en(s_pe), .o_pixel_x(s_x), .o_pixel_y(s_y), .o_visible(s_vis),
    .o_line_tick(s_lt), .o_frame_tick(s_ft), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_r(s_r), .o_g(s_g), .o_b(s_b)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b1), .CLK_DIV(1), .TICK_LINE(7)
  ) u_p (
    .i_clk(clk), .i_reset_n(rst_n), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_pix_en(p_pe), .o_pixel_x(p_x), .o_pixel_y(p_y), .o_visible(p_vis),
    .o_line_tick(p_lt), .o_frame_tick(p_ft), .o_hsync(p_hs), .o_vsync(p_vs),
    .o_r(p_r), .o_g(p_g), .o_b(p_b)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0), .CLK_DIV(2), .TICK_LINE(7)
  ) u_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_pix_en(c_pe), .o_pixel_x(c_x), .o_pixel_y(c_y), .o_visible(c_vis),
    .o_line_tick(c_lt), .o_frame_tick(c_ft), .o_hsync(c_hs), .o_vsync(c_vs),
    .o_r(c_r), .o_g(c_g), .o_b(c_b)
  );

  // Expected reduced-raster outputs at the j-th falling edge after release
  // (j >= 1). Pixel index p advances once per strobe; registered outputs
  // show pixel p-1, or reset values before the first capture.
  function automatic logic [28:0] model(input int j, input int d, input logic sa,
                                        input logic [2:0] rgb);
    int   p, x, y, px, py;
    logic pe, vis, hs, vs;
    logic [2:0] c;
    pe  = (j % d) == 0;
    p   = (j - 1) / d;
    x   = p % HT;
    y   = (p / HT) % VT;
    vis = (x < HV) && (y < VV);
    hs  = ~sa;
    vs  = ~sa;
    c   = 3'b000;
    if (p > 0) begin
      px = (p - 1) % HT;
      py = ((p - 1) / HT) % VT;
      hs = (px >= HS_LO && px <= HS_HI) ? sa : ~sa;
      vs = (py >= VS_LO && py <= VS_HI) ? sa : ~sa;
      c  = (px < HV && py < VV) ? rgb : 3'b000;
    end
    return {pe, 10'(x), 10'(y), vis, pe && (x == HT - 1), pe && (x == 0) && (y == TL), hs, vs, c};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (d0_obs !== RST_OBS) begin
      failures++;
      $display("FAIL reset_d0 got=%h exp=%h", d0_obs, RST_OBS);
    end
    checks++;
    if ({p_hs, p_vs} !== 2'b00) begin
      failures++;
      $display("FAIL reset_sync_inv got=%b exp=00", {p_hs, p_vs});
    end
    checks++;
    if (c_pe !== 1'b0) begin
      failures++;
      $display("FAIL reset_pix_en_div2 got=%b exp=0", c_pe);
    end
  endtask

  task automatic test_line_wrap();
    do_reset();
    for (int j = 1; j <= 801; j++) begin
      @(negedge clk);
      case (j)
        1: begin
          checks++;
          if ({d0_pe, d0_x, d0_r, d0_g, d0_b, d0_hs} !== {1'b1, 10'd0, 3'b000, 1'b1}) begin
            failures++;
            $display("FAIL first_pix got pe=%b x=%0d rgb=%b hs=%b exp pe=1 x=0 rgb=000 hs=1",
                     d0_pe, d0_x, {d0_r, d0_g, d0_b}, d0_hs);
          end
        end
        2, 641: begin
          checks++;
          if ({d0_r, d0_g, d0_b} !== 3'b111) begin
            failures++;
            $display("FAIL rgb_visible j=%0d got=%b exp=111", j, {d0_r, d0_g, d0_b});
          end
        end
        642: begin
          checks++;
          if ({d0_r, d0_g, d0_b} !== 3'b000) begin
            failures++;
            $display("FAIL rgb_blank_x640 got=%b exp=000", {d0_r, d0_g, d0_b});
          end
        end
        657, 754: begin
          checks++;
          if (d0_hs !== 1'b1) begin
            failures++;
            $display("FAIL hsync_idle j=%0d x=%0d got=%b exp=1", j, d0_x, d0_hs);
          end
        end
        658, 753: begin
          checks++;
          if (d0_hs !== 1'b0) begin
            failures++;
            $display("FAIL hsync_pulse j=%0d x=%0d got=%b exp=0", j, d0_x, d0_hs);
          end
        end
        799: begin
          checks++;
          if ({d0_x, d0_lt} !== {10'd798, 1'b0}) begin
            failures++;
            $display("FAIL pre_wrap got x=%0d lt=%b exp x=798 lt=0", d0_x, d0_lt);
          end
        end
        800: begin
          checks++;
          if ({d0_x, d0_y, d0_lt, d0_vs} !== {10'd799, 10'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL x799_line_tick got x=%0d y=%0d lt=%b vs=%b exp x=799 y=0 lt=1 vs=1",
                     d0_x, d0_y, d0_lt, d0_vs);
          end
        end
        801: begin
          checks++;
          if ({d0_x, d0_y, d0_lt} !== {10'd0, 10'd1, 1'b0}) begin
            failures++;
            $display("FAIL x_wrap got x=%0d y=%0d lt=%b exp x=0 y=1 lt=0", d0_x, d0_y, d0_lt);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_full_frame();
    int ft_cnt = 0, lt_cnt = 0, ft_first = 0, ft_last = 0;
    int hs_low = 0, vs_low = 0, r_high = 0;
    logic [28:0] exp_s, exp_p;
    do_reset();
    for (int j = 1; j <= 2 * FRAME + 3; j++) begin
      @(negedge clk);
      exp_s = model(j, 1, 1'b0, 3'b111);
      exp_p = model(j, 1, 1'b1, 3'b111);
      checks++;
      if (s_obs !== exp_s) begin
        failures++;
        $display("FAIL raster_default j=%0d got=%h exp=%h", j, s_obs, exp_s);
      end
      checks++;
      if (p_obs !== exp_p) begin
        failures++;
        $display("FAIL raster_sync_inv j=%0d got=%h exp=%h", j, p_obs, exp_p);
      end
      if (s_ft === 1'b1) begin
        ft_cnt++;
        if (ft_cnt == 1) ft_first = j;
        ft_last = j;
      end
      if (s_lt === 1'b1) lt_cnt++;
      if (j >= 2 && j <= FRAME + 1) begin
        if (s_hs === 1'b0) hs_low++;
        if (s_vs === 1'b0) vs_low++;
        if (s_r === 1'b1) r_high++;
      end
    end
    checks++;
    if (ft_cnt != 2) begin
      failures++;
      $display("FAIL frame_tick_count got=%0d exp=2", ft_cnt);
    end
    checks++;
    if (ft_last - ft_first != FRAME) begin
      failures++;
      $display("FAIL frame_period got=%0d exp=%0d", ft_last - ft_first, FRAME);
    end
    checks++;
    if (lt_cnt != 24) begin
      failures++;
      $display("FAIL line_tick_count got=%0d exp=24", lt_cnt);
    end
    checks++;
    if ({hs_low, vs_low, r_high} != {32'd36, 32'd46, 32'd96}) begin
      failures++;
      $display("FAIL frame_totals got hs_low=%0d vs_low=%0d r_high=%0d exp 36 46 96",
               hs_low, vs_low, r_high);
    end
  endtask

  task automatic test_clk_div();
    int ft_cnt = 0, ft_first = 0, ft_last = 0;
    logic [28:0] exp_c;
    do_reset();
    for (int j = 1; j <= 4 * FRAME + 4; j++) begin
      @(negedge clk);
      exp_c = model(j, 2, 1'b0, 3'b111);
      checks++;
      if (c_obs !== exp_c) begin
        failures++;
        $display("FAIL raster_div2 j=%0d got=%h exp=%h", j, c_obs, exp_c);
      end
      if (c_ft === 1'b1) begin
        ft_cnt++;
        if (ft_cnt == 1) ft_first = j;
        ft_last = j;
      end
    end
    checks++;
    if (ft_cnt != 2 || ft_last - ft_first != 2 * FRAME) begin
      failures++;
      $display("FAIL frame_period_div2 got count=%0d period=%0d exp count=2 period=%0d",
               ft_cnt, ft_last - ft_first, 2 * FRAME);
    end
  endtask

  task automatic test_colour();
    logic [28:0] exp_s;
    in_r = 1'b1; in_g = 1'b0; in_b = 1'b1;
    do_reset();
    for (int j = 1; j <= 2 * HT + 2; j++) begin
      @(negedge clk);
      exp_s = model(j, 1, 1'b0, 3'b101);
      checks++;
      if (s_obs !== exp_s) begin
        failures++;
        $display("FAIL colour_101 j=%0d got=%h exp=%h", j, s_obs, exp_s);
      end
    end
    in_r = 1'b1; in_g = 1'b1; in_b = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [28:0] exp_s;
    do_reset();
    for (int j = 1; j <= 4 * HT + 11; j++) begin
      @(negedge clk);
    end
    exp_s = model(4 * HT + 11, 1, 1'b0, 3'b111);
    checks++;
    if (s_obs !== exp_s) begin
      failures++;
      $display("FAIL pre_mid_reset got=%h exp=%h", s_obs, exp_s);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_obs !== RST_OBS) begin
      failures++;
      $display("FAIL mid_reset_async got=%h exp=%h", s_obs, RST_OBS);
    end
    checks++;
    if ({p_hs, p_vs, p_r} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_sync_inv got=%b exp=000", {p_hs, p_vs, p_r});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      exp_s = model(j, 1, 1'b0, 3'b111);
      checks++;
      if (s_obs !== exp_s) begin
        failures++;
        $display("FAIL restart_after_reset j=%0d got=%h exp=%h", j, s_obs, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_full_frame();
    test_clk_div();
    test_colour();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
